echo_multitap_core: RTL

Parametrised, runtime-programmable echo engine for the codec sample path; successor to the fixed single-delay echo stage. Each new input sample is mixed with an attenuated copy of a sample from `delay_len` samples earlier. The history lives in a circular RAM buffer, and the block can run feed-forward (single echo) or feedback (decaying repeats). It sits between the sample source and the codec output register, using the same `new_sample_ready` strobe.

---
 rtl/echo_multitap_core.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/echo_multitap_core.sv
// Runtime-programmable echo: each captured sample is mixed with an attenuated sample from
// delay_len samples earlier in a circular RAM. Define ECHO_SATURATE_EN to clamp the mix instead of wrapping.
module echo_multitap_core #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 12,
  parameter int SHIFT_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                echo_enable,
  input  logic                feedback_mode,
  input  logic [ADDR_W-1:0]   delay_len,
  input  logic [SHIFT_W-1:0]  decay_shift,
  output logic [SAMPLE_W-1:0] sample_to_codec,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun,
  output logic [1:0]          state_dbg
);

  // Handshake: a sample is accepted on a 0->1 edge of new_sample_ready seen while idle;
  // sample_valid pulses for exactly one cycle when sample_to_codec takes its new value.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_MIX   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state, state_next;

  logic                strobe_q;
  logic                edge_seen;
  logic                capture;
  logic [SAMPLE_W-1:0] smp_q;
  logic                en_q;
  logic                fb_q;
  logic [ADDR_W-1:0]   dl_q;
  logic [SHIFT_W-1:0]  sh_q;
  logic [ADDR_W-1:0]   wp;
  logic [ADDR_W:0]     fill;
  logic [SAMPLE_W-1:0] wr_data;
  logic [SAMPLE_W-1:0] rd_data;
  logic [ADDR_W-1:0]   ra;
  logic [ADDR_W:0]     eff_delay;
  logic                echo_ok;
  logic signed [SAMPLE_W-1:0] shifted;
  logic [SAMPLE_W-1:0] echo_term;
  logic [SAMPLE_W:0]   sum;
  logic [SAMPLE_W-1:0] reduced;
  logic [SAMPLE_W-1:0] mix_out;
  logic [SAMPLE_W-1:0] store_val;
  logic                mem_we;

  logic [SAMPLE_W-1:0] mem [0:(1<<ADDR_W)-1];

  localparam logic [ADDR_W:0]     FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [SAMPLE_W-1:0] SAT_MAX    = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAT_MIN    = {1'b1, {(SAMPLE_W-1){1'b0}}};

  assign edge_seen = new_sample_ready & ~strobe_q;
  assign capture   = edge_seen && (state == S_IDLE);

  // delay_len == 0 means a full buffer; modulo the depth that is the same address as wp
  assign ra        = wp - dl_q;
  assign eff_delay = (dl_q == '0) ? FULL_DEPTH : {1'b0, dl_q};
  assign echo_ok   = en_q && (fill >= eff_delay);
  assign shifted   = $signed(rd_data) >>> sh_q;
  assign echo_term = echo_ok ? shifted : '0;
  assign sum       = {smp_q[SAMPLE_W-1], smp_q} + {echo_term[SAMPLE_W-1], echo_term};

`ifdef ECHO_SATURATE_EN
  always_comb begin
    reduced = sum[SAMPLE_W-1:0];
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) reduced = sum[SAMPLE_W] ? SAT_MIN : SAT_MAX;
  end
`else
  assign reduced = sum[SAMPLE_W-1:0];
`endif

  assign mix_out   = en_q ? reduced : smp_q;
  assign store_val = (en_q && fb_q) ? reduced : smp_q;
  assign mem_we    = (state == S_WRITE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (capture) state_next = S_READ;
      S_READ:  state_next = S_MIX;
      S_MIX:   state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Buffer RAM is deliberately not reset; the fill guard hides stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wp] <= wr_data;
    rd_data <= mem[ra];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      strobe_q        <= 1'b0;
      smp_q           <= '0;
      en_q            <= 1'b0;
      fb_q            <= 1'b0;
      dl_q            <= '0;
      sh_q            <= '0;
      wp              <= '0;
      fill            <= '0;
      wr_data         <= '0;
      sample_to_codec <= '0;
      overrun         <= 1'b0;
    end else begin
      state    <= state_next;
      strobe_q <= new_sample_ready;
      if (capture) begin
        smp_q <= sample_in;
        en_q  <= echo_enable;
        fb_q  <= feedback_mode;
        dl_q  <= delay_len;
        sh_q  <= decay_shift;
      end
      if (edge_seen && (state != S_IDLE)) overrun <= 1'b1;
      if (state == S_MIX) begin
        sample_to_codec <= mix_out;
        wr_data         <= store_val;
      end
      if (state == S_WRITE) begin
        wp <= wp + 1'b1;
        if (fill != FULL_DEPTH) fill <= fill + 1'b1;
      end
    end
  end

  assign sample_valid = (state == S_WRITE);
  assign busy         = (state != S_IDLE);
  assign state_dbg    = state;

endmodule
